alu_muldiv_seq: RTL and testbench

Multi-cycle sequencer that implements the two ALU operation codes the combinational ALU leaves unimplemented. AluOP=3 is an unsigned multiply; AluOP=4 is an unsigned divide. The block sits beside the ALU in the execute stage. Its Busy output stalls the pipeline while the operation iterates. When it finishes, it drives the low/quotient word on Result and the high/remainder word on Result_2, and the execute stage multiplexes these in place of the ALU's zero outputs for codes 3 and 4. It uses a radix-2 shift-add datapath for multiply and a restoring shift-subtract datapath for divide, one bit per clock.

---
 rtl/alu_muldiv_seq.sv | 111 +++++++++++
 tb/tb_alu_muldiv_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply (AluOP=3) and divide (AluOP=4) beside the ALU.
// Both datapaths retire one bit per clock through a shared pair of accumulator words.
module alu_muldiv_seq #(
  parameter int NrOfBits = 32,
  parameter int CntBits  = 6
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                Start,
  input  logic [3:0]          AluOP,
  input  logic [NrOfBits-1:0] X,
  input  logic [NrOfBits-1:0] Y,
  output logic                Busy,
  output logic                Done,
  output logic [NrOfBits-1:0] Result,
  output logic [NrOfBits-1:0] Result_2
);

  localparam int N = NrOfBits;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state, state_nxt;
  logic [CntBits-1:0] cnt;
  logic [N-1:0]       x_q, y_q;
  // acc_hi/acc_lo are P_hi/P_lo while multiplying and R/Q while dividing.
  logic [N-1:0]       acc_hi, acc_lo;
  logic               div_zero;

  logic               accept, last, stepping;
  logic [N:0]         mul_sum, div_shift, div_diff;
  logic [N-1:0]       hi_nxt, lo_nxt;

  assign accept   = (state == IDLE || state == DONE) && Start &&
                    (AluOP == OP_MUL || AluOP == OP_DIV);
  assign last     = (cnt == CntBits'(N - 1));
  assign stepping = (state == MUL) || (state == DIV && !div_zero);

  // A divide by zero retires without iterating, so it never stalls the pipeline.
  assign Busy = stepping;
  assign Done = (state == DONE);

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it holding a previous value and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (AluOP == OP_MUL) ? MUL : DIV;
      MUL:  if (last) state_nxt = DONE;
      DIV:  if (div_zero || last) state_nxt = DONE;
      DONE: state_nxt = accept ? ((AluOP == OP_MUL) ? MUL : DIV) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mul_sum   = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, x_q}) : {1'b0, acc_hi};
    div_shift = {acc_hi, acc_lo[N-1]};
    div_diff  = div_shift - {1'b0, y_q};
    hi_nxt    = acc_hi;
    lo_nxt    = acc_lo;
    if (state == MUL) begin
      hi_nxt = mul_sum[N:1];
      lo_nxt = {mul_sum[0], acc_lo[N-1:1]};
    end else begin
      // A clear top bit of the difference means the trial subtraction fits.
      hi_nxt = div_diff[N] ? div_shift[N-1:0] : div_diff[N-1:0];
      lo_nxt = {acc_lo[N-2:0], ~div_diff[N]};
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      div_zero <= 1'b0;
      Result   <= '0;
      Result_2 <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        x_q      <= X;
        y_q      <= Y;
        cnt      <= '0;
        acc_hi   <= '0;
        acc_lo   <= (AluOP == OP_MUL) ? Y : X;
        div_zero <= (AluOP == OP_DIV) && (Y == '0);
      end else if (stepping) begin
        acc_hi <= hi_nxt;
        acc_lo <= lo_nxt;
        cnt    <= last ? cnt : cnt + 1'b1;
        if (last) begin
          Result   <= lo_nxt;
          Result_2 <= hi_nxt;
        end
      end else if (state == DIV) begin
        Result   <= '1;
        Result_2 <= x_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq against an arithmetic reference model.
module tb_alu_muldiv_seq;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Start = 1'b0;
  logic [3:0]  AluOP = 4'd0;
  logic [31:0] X = '0;
  logic [31:0] Y = '0;
  logic        Busy, Done;
  logic [31:0] Result, Result_2;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_lo = '0;
  logic [31:0] last_hi = '0;

  alu_muldiv_seq #(.NrOfBits(32), .CntBits(6)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .AluOP(AluOP), .X(X), .Y(Y),
    .Busy(Busy), .Done(Done), .Result(Result), .Result_2(Result_2)
  );

  always #5 CLK = ~CLK;

  // Reference: {high/remainder, low/quotient} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 4'd3) return {32'd0, a} * {32'd0, b};
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  // Drive a request at a falling edge; returns at the falling edge after E0.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; AluOP = op; X = a; Y = b;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0; AluOP = 4'($urandom); X = $urandom; Y = $urandom;
  endtask

  // Polls falling edges starting at index n0 (index 1 lies between E0 and E1).
  task automatic wait_done(input string name, input int n0, input int exp_lat, input int exp_busy,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi, input bit drop);
    int n = n0;
    int busy_cnt = 0;
    bit seen = 0;
    while (n <= 100) begin
      total++;
      if (Busy && Done) begin
        bad++; $display("FAIL %s overlap: Busy=%b Done=%b at idx %0d, need not both", name, Busy, Done, n);
      end
      if (Busy) busy_cnt++;
      if (Done) begin seen = 1; break; end
      @(negedge CLK); n++;
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL %s timeout: no Done within 100 cycles", name);
    end else begin
      total += 4;
      if (n !== exp_lat) begin bad++; $display("FAIL %s latency: got %0d need %0d", name, n, exp_lat); end
      if (busy_cnt !== exp_busy) begin bad++; $display("FAIL %s busy cycles: got %0d need %0d", name, busy_cnt, exp_busy); end
      if (Result !== exp_lo) begin bad++; $display("FAIL %s Result: got %h need %h", name, Result, exp_lo); end
      if (Result_2 !== exp_hi) begin bad++; $display("FAIL %s Result_2: got %h need %h", name, Result_2, exp_hi); end
    end
    last_lo = exp_lo; last_hi = exp_hi;
    if (drop) begin
      @(negedge CLK);
      total += 2;
      if (Done !== 1'b0 || Busy !== 1'b0) begin
        bad++; $display("FAIL %s after: Done=%b Busy=%b need 0 0", name, Done, Busy);
      end
      if (Result !== exp_lo || Result_2 !== exp_hi) begin
        bad++; $display("FAIL %s hold: got %h/%h need %h/%h", name, Result, Result_2, exp_lo, exp_hi);
      end
    end
  endtask

  // Full request with hold check at index 1 and completion check.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e = model(op, a, b);
    bit dz = (op == 4'd4) && (b == 32'd0);
    issue(op, a, b);
    total++;
    if (Result !== last_lo || Result_2 !== last_hi) begin
      bad++; $display("FAIL %s early: got %h/%h need held %h/%h", name, Result, Result_2, last_lo, last_hi);
    end
    wait_done(name, 1, dz ? 2 : 33, dz ? 0 : 32, e[31:0], e[63:32], 1'b1);
  endtask

  task automatic test_reset;
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      total++;
      if (Busy !== 1'b0 || Done !== 1'b0 || Result !== '0 || Result_2 !== '0) begin
        bad++; $display("FAIL reset idle: Busy=%b Done=%b R=%h R2=%h need all 0", Busy, Done, Result, Result_2);
      end
    end
  endtask

  task automatic test_mul_max;
    run_op("mul_max", 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    total++;
    if (last_lo !== 32'h0000_0001 || last_hi !== 32'hFFFF_FFFE) begin
      bad++; $display("FAIL mul_max model: got %h/%h need 00000001/fffffffe", last_lo, last_hi);
    end
  endtask

  task automatic test_div;
    run_op("div_100_7", 4'd4, 32'd100, 32'd7);
    run_op("div_msb_3", 4'd4, 32'h8000_0000, 32'd3);
    run_op("div_small_big", 4'd4, 32'd5, 32'hFFFF_FFFF);
  endtask

  task automatic test_div_zero;
    run_op("div_zero", 4'd4, 32'h0000_1234, 32'd0);
  endtask

  task automatic test_ignored;
    int dones = 0;
    Start = 1'b1; AluOP = 4'd5; X = 32'd9; Y = 32'd9;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    repeat (5) begin
      total++;
      if (Busy !== 1'b0 || Done !== 1'b0 || Result !== last_lo) begin
        bad++; $display("FAIL ignored op5: Busy=%b Done=%b R=%h need 0 0 %h", Busy, Done, Result, last_lo);
      end
      @(negedge CLK);
    end
    issue(4'd3, 32'd6, 32'd7);
    repeat (8) @(negedge CLK);
    Start = 1'b1; AluOP = 4'd3; X = 32'd2; Y = 32'd3;
    @(negedge CLK);
    Start = 1'b0;
    wait_done("busy_start", 10, 33, 23, 32'd42, 32'd0, 1'b1);
    repeat (35) begin
      @(negedge CLK);
      if (Done) dones++;
    end
    total++;
    if (dones !== 0) begin bad++; $display("FAIL busy_start extra Done: got %0d need 0", dones); end
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    int busys = 0;
    issue(4'd3, $urandom, $urandom);
    repeat (14) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    total++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Result !== '0 || Result_2 !== '0) begin
      bad++; $display("FAIL reset_mid async: Busy=%b Done=%b R=%h R2=%h need all 0", Busy, Done, Result, Result_2);
    end
    @(negedge CLK); RST = 1'b0;
    last_lo = '0; last_hi = '0;
    repeat (40) begin
      @(negedge CLK);
      if (Done) dones++;
      if (Busy) busys++;
    end
    total++;
    if (dones !== 0 || busys !== 0 || Result !== '0) begin
      bad++; $display("FAIL reset_mid after: dones=%0d busys=%0d R=%h need 0 0 0", dones, busys, Result);
    end
  endtask

  task automatic test_back_to_back;
    issue(4'd3, 32'd6, 32'd7);
    wait_done("b2b_mul", 1, 33, 32, 32'd42, 32'd0, 1'b0);
    Start = 1'b1; AluOP = 4'd4; X = 32'd9; Y = 32'd2;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0; X = $urandom; Y = $urandom;
    total++;
    if (Done !== 1'b0 || Busy !== 1'b1 || Result !== 32'd42) begin
      bad++; $display("FAIL b2b handoff: Done=%b Busy=%b R=%0d need 0 1 42", Done, Busy, Result);
    end
    wait_done("b2b_div", 1, 33, 32, 32'd4, 32'd1, 1'b1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      logic [3:0]  op = ($urandom_range(0, 1) == 0) ? 4'd3 : 4'd4;
      logic [31:0] a = $urandom;
      logic [31:0] b;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 255));
      run_op($sformatf("rand%0d", i), op, a, b);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    test_reset();
    test_mul_max();
    test_div();
    test_div_zero();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
